// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the next-PC generator.
`timescale 1ns/1ps
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam int unsigned CAUSE_IADDR_MISALIGNED = 0;
  localparam int unsigned CAUSE_ECALL_M          = 11;
  localparam logic [1:0]  MTVEC_MODE_VECTORED    = 2'b01;

endpackage

// File: rtl/pc_gen_npc_sel.sv
// Combinational next-PC priority mux: trap, misaligned target, irq, mret, jump, branch, sequential.
`timescale 1ns/1ps
module npc_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IALIGN   = 32,
  parameter int unsigned IRQ_CODE = 7
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_jump_flag,
  input  logic            i_branch_flag,
  input  logic            i_is_mret,
  input  logic            i_is_ecall,
  input  logic            i_irq_pending,
  input  logic [XLEN-1:0] i_jump_target,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic [XLEN-1:0] i_snpc,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic [XLEN-1:0] o_npc,
  output logic            o_trap,
  output logic            o_retire,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_epc
);

  localparam bit ALIGN16 = (IALIGN == 16);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_seq_npc;
  logic [1:0]      w_tgt_lo;
  logic            w_misaligned;

  // Jump wins over branch both for the selected target and its alignment check
  always_comb begin
    w_base       = {i_mtvec[XLEN-1:2], 2'b00};
    w_tgt_lo     = i_jump_flag ? i_jump_target[1:0] : i_branch_target[1:0];
    w_misaligned = (i_jump_flag || i_branch_flag) &&
                   (ALIGN16 ? w_tgt_lo[0] : (w_tgt_lo != 2'b00));
    if (i_is_mret)          w_seq_npc = i_mepc;
    else if (i_jump_flag)   w_seq_npc = i_jump_target;
    else if (i_branch_flag) w_seq_npc = i_branch_target;
    else                    w_seq_npc = i_snpc;
  end

  always_comb begin
    o_npc    = w_seq_npc;
    o_trap   = 1'b0;
    o_retire = 1'b1;
    o_cause  = '0;
    o_epc    = '0;
    if (i_is_ecall) begin
      o_npc    = w_base;
      o_trap   = 1'b1;
      o_retire = 1'b0;
      o_cause  = XLEN'(CAUSE_ECALL_M);
      o_epc    = i_pc;
    end else if (w_misaligned) begin
      o_npc    = w_base;
      o_trap   = 1'b1;
      o_retire = 1'b0;
      o_cause  = XLEN'(CAUSE_IADDR_MISALIGNED);
      o_epc    = i_pc;
    end else if (i_irq_pending) begin
      // The instruction retires; the interrupt returns to where it would have gone
      o_trap  = 1'b1;
      o_cause = {1'b1, (XLEN-1)'(IRQ_CODE)};
      o_epc   = w_seq_npc;
      o_npc   = (i_mtvec[1:0] == MTVEC_MODE_VECTORED) ?
                w_base + XLEN'(4 * IRQ_CODE) : w_base;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Architectural PC owner: offers PCs to the IFU, applies commits, tracks traps and instret.
`timescale 1ns/1ps
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter int unsigned     IALIGN    = 32,
  parameter int unsigned     CNT_W     = 64,
  parameter int unsigned     IRQ_CODE  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic [XLEN-1:0]  pc,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic             jump_flag,
  input  logic             branch_flag,
  input  logic             is_mret,
  input  logic             is_ecall,
  input  logic             irq_pending,
  input  logic [XLEN-1:0]  jump_target,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  snpc,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic             trap_taken,
  output logic [XLEN-1:0]  trap_cause,
  output logic [XLEN-1:0]  trap_epc,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_pc_valid;
  logic             r_commit_ready;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_instret;
  logic             r_trap_taken;
  logic [XLEN-1:0]  r_trap_cause;
  logic [XLEN-1:0]  r_trap_epc;

  logic             w_commit;
  logic [XLEN-1:0]  w_npc;
  logic             w_trap;
  logic             w_retire;
  logic [XLEN-1:0]  w_cause;
  logic [XLEN-1:0]  w_epc;

  npc_sel #(
    .XLEN     (XLEN),
    .IALIGN   (IALIGN),
    .IRQ_CODE (IRQ_CODE)
  ) u_npc_sel (
    .i_pc            (r_pc),
    .i_jump_flag     (jump_flag),
    .i_branch_flag   (branch_flag),
    .i_is_mret       (is_mret),
    .i_is_ecall      (is_ecall),
    .i_irq_pending   (irq_pending),
    .i_jump_target   (jump_target),
    .i_branch_target (branch_target),
    .i_snpc          (snpc),
    .i_mtvec         (mtvec),
    .i_mepc          (mepc),
    .o_npc           (w_npc),
    .o_trap          (w_trap),
    .o_retire        (w_retire),
    .o_cause         (w_cause),
    .o_epc           (w_epc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_RESET: w_state_nxt = S_ISSUE;
      S_ISSUE: if (pc_ready) w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_commit = commit_valid;
        if (commit_valid) w_state_nxt = S_ISSUE;
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RESET;
      r_pc_valid     <= 1'b0;
      r_commit_ready <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc_valid     <= (w_state_nxt == S_ISSUE);
      r_commit_ready <= (w_state_nxt == S_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_VEC;
      r_instret    <= '0;
      r_trap_taken <= 1'b0;
      r_trap_cause <= '0;
      r_trap_epc   <= '0;
    end else begin
      r_trap_taken <= w_commit && w_trap;
      if (w_commit) begin
        r_pc <= w_npc;
        if (w_retire) r_instret <= r_instret + CNT_W'(1);
        if (w_trap) begin
          r_trap_cause <= w_cause;
          r_trap_epc   <= w_epc;
        end
      end
    end
  end

  assign pc_valid     = r_pc_valid;
  assign commit_ready = r_commit_ready;
  assign pc           = r_pc;
  assign instret      = r_instret;
  assign trap_taken   = r_trap_taken;
  assign trap_cause   = r_trap_cause;
  assign trap_epc     = r_trap_epc;

endmodule
